// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes over a WINDOW-cycle window and offers each result on a
// 1-deep valid/ready buffer. Define SPIKE_RATE_EMA_EN to output an EMA of the window counts.
module spike_rate_decoder #(
   parameter int unsigned WINDOW = 256,
   parameter int unsigned CNT_W  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spike,
   input  logic       enable,
   output logic [7:0] rate_out,
   output logic       rate_sat,
   output logic       rate_valid,
   input  logic       rate_ready,
   output logic       overrun
);

   localparam int unsigned       WC_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] SC_MAX  = {CNT_W{1'b1}};

   typedef enum logic {StEmpty, StFull} buf_state_e;

   buf_state_e       state_q;
   logic [WC_W-1:0]  wc_q;
   logic [CNT_W-1:0] sc_q;
   logic             sat_q;
   logic [CNT_W-1:0] sc_inc;
   logic             sat_inc;
   logic             win_end;
   logic [7:0]       count8;
   logic [7:0]       load_val;

   // sc_inc/sat_inc already include this cycle's spike, so they are the window result at win_end
   always_comb begin
      win_end = enable && (wc_q == WC_LAST);
      sc_inc  = sc_q;
      sat_inc = sat_q;
      if (enable && spike) begin
         if (sc_q == SC_MAX) begin
            sat_inc = 1'b1;
         end else begin
            sc_inc = sc_q + CNT_W'(1);
         end
      end
      count8              = '0;
      count8[CNT_W-1:0]   = sc_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wc_q  <= '0;
         sc_q  <= '0;
         sat_q <= 1'b0;
      end else if (enable) begin
         if (win_end) begin
            wc_q  <= '0;
            sc_q  <= '0;
            sat_q <= 1'b0;
         end else begin
            wc_q  <= wc_q + WC_W'(1);
            sc_q  <= sc_inc;
            sat_q <= sat_inc;
         end
      end
   end

`ifdef SPIKE_RATE_EMA_EN
   logic [7:0]        ema_q;
   logic [7:0]        ema_nx;
   logic signed [8:0] ema_diff;
   logic signed [8:0] ema_step;

   // ema += floor((count - ema) / 4); the result always stays within 0..255
   always_comb begin
      ema_diff = $signed({1'b0, count8}) - $signed({1'b0, ema_q});
      ema_step = ema_diff >>> 2;
      ema_nx   = ema_q + ema_step[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ema_q <= '0;
      end else if (win_end) begin
         ema_q <= ema_nx;
      end
   end

   assign load_val = ema_nx;
`else
   assign load_val = count8;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StEmpty;
         rate_out   <= '0;
         rate_sat   <= 1'b0;
         rate_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         unique case (state_q)
            StEmpty: begin
               if (win_end) begin
                  state_q    <= StFull;
                  rate_out   <= load_val;
                  rate_sat   <= sat_inc;
                  rate_valid <= 1'b1;
               end
            end
            StFull: begin
               if (win_end) begin
                  // accept and reload on the same edge so back-to-back results leave no bubble
                  if (rate_ready) begin
                     rate_out <= load_val;
                     rate_sat <= sat_inc;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else if (rate_ready) begin
                  state_q    <= StEmpty;
                  rate_valid <= 1'b0;
               end
            end
            default: begin
               state_q    <= StEmpty;
               rate_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: randomized phases against a window-counting reference model,
// with a result scoreboard popped by a monitor on every valid/ready transfer.
module tb_spike_rate_decoder;

   localparam int unsigned WINDOW = 20;
   localparam int unsigned CNT_W  = 4;
   localparam int          MAXC   = (1 << CNT_W) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spike = 1'b0;
   logic       enable = 1'b0;
   logic       rate_ready = 1'b0;
   logic [7:0] rate_out;
   logic       rate_sat;
   logic       rate_valid;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int val;
      bit sat;
   } res_t;

   res_t exp_q[$];
   int   m_wc   = 0;
   int   m_cnt  = 0;
   int   m_ema  = 0;
   bit   m_occ  = 1'b0;
   bit   m_ovr  = 1'b0;
   bit   m_zero = 1'b1;

   always #5 clk = ~clk;

   spike_rate_decoder #(
      .WINDOW (WINDOW),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spike      (spike),
      .enable     (enable),
      .rate_out   (rate_out),
      .rate_sat   (rate_sat),
      .rate_valid (rate_valid),
      .rate_ready (rate_ready),
      .overrun    (overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: counts spikes per window as a plain integer, clamps at the end.
   task automatic model(input bit r, input bit e, input bit s, input bit rd);
      bit   ending;
      res_t res;
      int   d;
      if (r) begin
         m_wc   = 0;
         m_cnt  = 0;
         m_ema  = 0;
         m_occ  = 1'b0;
         m_ovr  = 1'b0;
         m_zero = 1'b1;
         exp_q.delete();
         return;
      end
      m_ovr  = 1'b0;
      ending = e && (m_wc == int'(WINDOW) - 1);
      if (e && s) m_cnt++;
      if (ending) begin
         res.val = (m_cnt > MAXC) ? MAXC : m_cnt;
         res.sat = (m_cnt > MAXC);
`ifdef SPIKE_RATE_EMA_EN
         d       = res.val - m_ema;
         m_ema   = m_ema + ((d >= 0) ? d / 4 : -((-d + 3) / 4));
         res.val = m_ema;
`else
         d = 0;
`endif
         if (!m_occ || rd) begin
            exp_q.push_back(res);
            m_occ  = 1'b1;
            m_zero = 1'b0;
         end else begin
            m_ovr = 1'b1;
         end
         m_cnt = 0;
         m_wc  = 0;
      end else begin
         if (e) m_wc++;
         if (m_occ && rd) m_occ = 1'b0;
      end
   endtask

   task automatic step(input bit r, input bit e, input bit s, input bit rd);
      rst        = r;
      enable     = e;
      spike      = s;
      rate_ready = rd;
      @(posedge clk);
      model(r, e, s, rd);
      #1;
   endtask

   function automatic bit chance(input int pct);
      return $urandom_range(99) < pct;
   endfunction

   task automatic run_phase(input int n, input int p_spk, input int p_en, input int p_rdy,
                            input int p_rst);
      for (int i = 0; i < n; i++) begin
         step(chance(p_rst), chance(p_en), chance(p_spk), chance(p_rdy));
      end
   endtask

   // Monitor: outputs sampled on the falling edge, results popped on each transfer
   initial begin
      res_t r;
      forever begin
         @(negedge clk);
         check("rate_valid", rate_valid, m_occ);
         check("overrun", overrun, m_ovr);
         if (m_zero) begin
            check("rate_out_idle", rate_out, 0);
            check("rate_sat_idle", rate_sat, 0);
         end
         if (rate_valid === 1'b1 && rate_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %0d expected none at %0t", rate_out, $time);
            end else begin
               r = exp_q.pop_front();
               check("rate_out", rate_out, r.val);
               check("rate_sat", rate_sat, r.sat);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         step(1'b1, chance(50), chance(50), chance(50));
      end
      run_phase(80, 100, 100, 100, 0);   // every cycle spikes: saturated windows
      run_phase(200, 30, 100, 100, 0);
      run_phase(90, 50, 100, 0, 0);      // no ready: hold and overrun
      run_phase(300, 40, 70, 60, 0);
      run_phase(300, 10, 90, 30, 0);
      run_phase(300, 70, 50, 80, 0);
      run_phase(600, 45, 85, 50, 1);     // occasional mid-window resets
      run_phase(200, 60, 95, 90, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("pending_results", exp_q.size(), m_occ);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
